sampler_buffer_reader: RTL and testbench
========================================

# sampler_buffer_reader

Host-side drain engine for the lease sampler's record buffer. When the sampler buffer fills, or when the host commands it, the block walks buffer addresses 0..N-1 and reads the four parallel record memories (interval, PC/address, trace, target). It serializes each record into 32-bit words on a valid/ready stream toward the host comm path. After the last word is accepted, it pulses the sampler's buffer-clear so logging can resume.

## Interface
Parameters:
- BW_ADDR, 13, width of the sampler buffer address.
- N_MAX, 8192, maximum record count; requested counts above this are clamped to it.

Ports:
- clock_i  in  1  single clock; all logic on posedge.
- resetn_i  in  1  asynchronous, active-low reset.
- start_i  in  1  host drain command; single-cycle pulse, sampled only in IDLE.
- auto_i  in  1  when 1, a rising edge of full_i starts a drain exactly as start_i does.
- full_i  in  1  sampler buffer-full flag.
- used_i  in  32  record count to drain; latched at start.
- interval_i  in  32  sampler interval memory output.
- address_i  in  32  sampler PC memory output.
- trace_i  in  64  sampler trace memory output.
- target_i  in  32  sampler target memory output.
- ready_i  in  1  downstream accepts data_o.
- add_o  out  BW_ADDR  read address to the sampler buffer.
- data_o  out  32  stream word.
- valid_o  out  1  data_o valid.
- clear_o  out  1  one-cycle buffer-clear pulse to the sampler.
- busy_o  out  1  high in every state except IDLE.
- records_o  out  32  records fully transmitted in the current or most recent drain.

## Operation
- Stream format: one header word holding the clamped count C, then 5 words per record in this order: address_i, interval_i, trace_i[31:0], trace_i[63:32], target_i.
- States:
  - IDLE → HEADER on start_i, or on auto_i && full_i rising (full_i registered internally for edge detection). On entry, latch C = min(used_i, N_MAX), set records_o=0 and add_o=0.
  - HEADER: valid_o=1, data_o=C. On handshake, go to CLEAR if C==0, else to ADDR.
  - ADDR: add_o holds the record index. Go to WAIT.
  - WAIT: absorbs the 1-cycle BRAM read latency. Go to LOAD.
  - LOAD: capture all five words into internal holding registers. Set word index to 0. Go to SEND.
  - SEND: valid_o=1, data_o = holding word [index]. On handshake with index<4, increment the index. On handshake with index==4, increment records_o and go to NEXT.
  - NEXT: if records_o==C, go to CLEAR; else add_o+1 and go to ADDR.
  - CLEAR: clear_o=1 for exactly one cycle, then IDLE.
- Handshake: a transfer occurs only on posedge with valid_o&&ready_i. While valid_o=1 and ready_i=0, data_o is held stable. valid_o never drops without a transfer.
- add_o holds stable from ADDR through LOAD. Memory inputs are sampled only in LOAD; their values in other states are ignored.
- Width rules: compare C as 32 bits. add_o = index[BW_ADDR-1:0]. At C==N_MAX the last address is N_MAX-1 and add_o never wraps mid-drain. records_o saturates at C.
- Ignored inputs: start_i and full_i edges are ignored while busy_o=1. A change in used_i after the latch has no effect.
- Reset: resetn_i low at any time, including mid-record, forces IDLE immediately. Reset values: valid_o=0, clear_o=0, busy_o=0, data_o=0, add_o=0, records_o=0. No clear_o is issued for an aborted drain.

## Timing
- Start pulse at edge N: HEADER with valid_o=1 and data_o=C from cycle N+1.
- Header accepted at edge M: add_o=0 at M+1, LOAD at M+3, first record word valid at M+4.
- Record boundary: last word accepted at edge K gives NEXT at K+1, ADDR at K+2, next word0 valid at K+5.
  - Throughput with ready_i tied high: 9 cycles per record.
- Final transfer at edge K: clear_o high during cycle K+2 (NEXT at K+1, CLEAR at K+2). busy_o low from K+3.
- C==0: header accepted at edge M gives clear_o in cycle M+1.

## Test plan
- Basic drain, ready_i=1, used_i=3, distinct memory patterns per address → stream is 3, then 15 words in the specified order. Addresses 0,1,2 are each read once. clear_o pulses once. records_o=3.
- Backpressure: ready_i toggles pseudo-randomly, used_i=2 → data_o stays stable while stalled. Exactly 11 words transferred, no drops or duplicates.
- auto_i=1 with full_i rising, used_i=8192 → header word 8192. add_o runs 0..8191 without wrap. records_o=8192, then clear_o.
- Empty and clamped counts: used_i=0 → header 0 only, clear_o one cycle after the header handshake. used_i=20000 → header word 8192.
- Ignored start: start_i pulses while busy → no restart and no change to C; a second start after IDLE begins a fresh drain with records_o reset to 0.
- Reset mid-drain: assert resetn_i during SEND word 2 of record 1 → valid_o=0, busy_o=0, add_o=0 immediately. No clear_o is issued. A subsequent start drains from address 0.

Source files
------------

// File: rtl/sampler_buffer_reader.sv
// sampler_buffer_reader
// Drains the lease sampler's record buffer to the host. A drain starts on a
// host command or on a rising buffer-full flag (when auto mode is enabled).
// The block sends a header word with the clamped record count. It then walks
// the buffer and sends five 32-bit words per record on a valid/ready stream.
// At the end it pulses the sampler's buffer-clear.
module sampler_buffer_reader #(
    parameter int BW_ADDR = 13,
    parameter int N_MAX   = 8192
) (
    input  logic               clock_i,
    input  logic               resetn_i,
    input  logic               start_i,
    input  logic               auto_i,
    input  logic               full_i,
    input  logic [31:0]        used_i,
    input  logic [31:0]        interval_i,
    input  logic [31:0]        address_i,
    input  logic [63:0]        trace_i,
    input  logic [31:0]        target_i,
    input  logic               ready_i,
    output logic [BW_ADDR-1:0] add_o,
    output logic [31:0]        data_o,
    output logic               valid_o,
    output logic               clear_o,
    output logic               busy_o,
    output logic [31:0]        records_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_LOAD   = 3'd4;
    localparam logic [2:0] ST_SEND   = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;
    localparam logic [2:0] ST_CLEAR  = 3'd7;

    localparam logic [31:0]        N_MAX_W  = 32'(N_MAX);
    localparam logic [BW_ADDR-1:0] ADDR_ONE = {{(BW_ADDR-1){1'b0}}, 1'b1};

    // Requested record count limited to the buffer capacity.
    function automatic logic [31:0] clamp_count(input logic [31:0] req);
        if (req > N_MAX_W) begin
            return N_MAX_W;
        end else begin
            return req;
        end
    endfunction

    logic [2:0]         state_r;
    logic [31:0]        count_r;
    logic [31:0]        records_r;
    logic [BW_ADDR-1:0] add_r;
    logic [31:0]        hold_r [5];
    logic [2:0]         idx_r;
    logic               full_q_r;
    logic               valid_r;
    logic               clear_r;
    logic               busy_r;
    logic [31:0]        data_r;

    logic               trigger_s;
    logic               xfer_s;
    logic [31:0]        count_in_s;
    logic [31:0]        next_word_s;

    // Start detection, handshake and the next holding word to present.
    always_comb begin
        trigger_s   = start_i | (auto_i & full_i & ~full_q_r);
        xfer_s      = valid_r & ready_i;
        count_in_s  = clamp_count(used_i);
        next_word_s = hold_r[4];
        case (idx_r)
            3'd0:    next_word_s = hold_r[1];
            3'd1:    next_word_s = hold_r[2];
            3'd2:    next_word_s = hold_r[3];
            3'd3:    next_word_s = hold_r[4];
            default: next_word_s = hold_r[4];
        endcase
    end

    // Delayed copy of the full flag for rising-edge detection.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            full_q_r <= 1'b0;
        end else begin
            full_q_r <= full_i;
        end
    end

    // Drain sequencer; every output is registered alongside the state.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r   <= ST_IDLE;
            count_r   <= 32'd0;
            records_r <= 32'd0;
            add_r     <= {BW_ADDR{1'b0}};
            idx_r     <= 3'd0;
            valid_r   <= 1'b0;
            clear_r   <= 1'b0;
            busy_r    <= 1'b0;
            data_r    <= 32'd0;
            for (int i = 0; i < 5; i++) begin
                hold_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clear_r <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (trigger_s) begin
                        count_r   <= count_in_s;
                        records_r <= 32'd0;
                        add_r     <= {BW_ADDR{1'b0}};
                        data_r    <= count_in_s;
                        valid_r   <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (xfer_s) begin
                        valid_r <= 1'b0;
                        if (count_r == 32'd0) begin
                            clear_r <= 1'b1;
                            state_r <= ST_CLEAR;
                        end else begin
                            state_r <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    hold_r[0] <= address_i;
                    hold_r[1] <= interval_i;
                    hold_r[2] <= trace_i[31:0];
                    hold_r[3] <= trace_i[63:32];
                    hold_r[4] <= target_i;
                    data_r    <= address_i;
                    valid_r   <= 1'b1;
                    idx_r     <= 3'd0;
                    state_r   <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        if (idx_r < 3'd4) begin
                            idx_r  <= idx_r + 3'd1;
                            data_r <= next_word_s;
                        end else begin
                            valid_r <= 1'b0;
                            if (records_r < count_r) begin
                                records_r <= records_r + 32'd1;
                            end
                            state_r <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (records_r == count_r) begin
                        clear_r <= 1'b1;
                        state_r <= ST_CLEAR;
                    end else begin
                        add_r   <= add_r + ADDR_ONE;
                        state_r <= ST_ADDR;
                    end
                end
                ST_CLEAR: begin
                    clear_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    clear_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_o     = add_r;
    assign data_o    = data_r;
    assign valid_o   = valid_r;
    assign clear_o   = clear_r;
    assign busy_o    = busy_r;
    assign records_o = records_r;

endmodule

// File: tb/tb_sampler_buffer_reader.sv
// Directed testbench for sampler_buffer_reader: a registered memory model
// with per-address patterns, a stream monitor, and one task per scenario.
module tb_sampler_buffer_reader;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0, auto_i = 1'b0, full_i = 1'b0, ready_i = 1'b1;
    logic [31:0] used_i = 32'd0;
    logic [31:0] interval_i = 32'd0, address_i = 32'd0, target_i = 32'd0;
    logic [63:0] trace_i = 64'd0;
    logic [12:0] add_o;
    logic [31:0] data_o, records_o;
    logic        valid_o, clear_o, busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    sampler_buffer_reader #(.BW_ADDR(13), .N_MAX(8192)) dut (
        .clock_i(clock), .resetn_i(resetn), .start_i(start_i), .auto_i(auto_i),
        .full_i(full_i), .used_i(used_i), .interval_i(interval_i),
        .address_i(address_i), .trace_i(trace_i), .target_i(target_i),
        .ready_i(ready_i), .add_o(add_o), .data_o(data_o), .valid_o(valid_o),
        .clear_o(clear_o), .busy_o(busy_o), .records_o(records_o)
    );

    always #5 clock = ~clock;

    // Memory model with one cycle of read latency.
    always @(posedge clock) begin
        address_i  <= 32'hA000_0000 | 32'(add_o);
        interval_i <= 32'h1000_0000 + 32'(add_o) * 32'd3;
        trace_i    <= {32'hC000_0000 | 32'(add_o), 32'hB000_0000 | 32'(add_o)};
        target_i   <= 32'hD000_0000 | 32'(add_o);
    end

    logic [31:0] exp_c = 32'd0;

    // Expected stream word w of a drain (w==0 is the header).
    function automatic logic [31:0] exp_word(input int w);
        int rec;
        if (w == 0) return exp_c;
        rec = (w - 1) / 5;
        case ((w - 1) % 5)
            0:       return 32'hA000_0000 | 32'(rec);
            1:       return 32'h1000_0000 + 32'(rec) * 32'd3;
            2:       return 32'hB000_0000 | 32'(rec);
            3:       return 32'hC000_0000 | 32'(rec);
            default: return 32'hD000_0000 | 32'(rec);
        endcase
    endfunction

    int          word_idx = 0, word_err = 0, stall_err = 0, wrap_err = 0, clear_cnt = 0;
    int          max_add = 0;
    logic        prev_stall = 1'b0, prev_busy = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic [12:0] prev_add = 13'd0;

    // Stream monitor: word order, stall stability, address walk, clear pulses.
    always @(negedge clock) begin
        if (busy_o && !prev_busy) begin
            word_idx = 0;
            max_add  = 0;
            prev_add = add_o;
        end
        if (busy_o && prev_busy && add_o != prev_add && add_o != prev_add + 13'd1) wrap_err++;
        if (busy_o && int'(add_o) > max_add) max_add = int'(add_o);
        if (prev_stall && (!valid_o || data_o != prev_data)) stall_err++;
        if (clear_o) clear_cnt++;
        if (valid_o && ready_i) begin
            if (data_o !== exp_word(word_idx)) word_err++;
            word_idx++;
        end
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
        prev_busy  = busy_o;
        prev_add   = add_o;
    end

    task automatic pulse_start(input logic [31:0] used);
        @(posedge clock); #1;
        used_i  = used;
        start_i = 1'b1;
        @(posedge clock); #1;
        start_i = 1'b0;
    endtask

    // Waits for clear_o; d is the number of cycles after the start edge.
    task automatic wait_clear(input int budget, input bit rnd, output int d,
                              output logic hv, output logic [31:0] hd, output logic [31:0] hr);
        hv = 1'b0; hd = 32'd0; hr = 32'd0;
        for (d = 0; d < budget; d++) begin
            @(negedge clock);
            if (d == 0) begin hv = valid_o; hd = data_o; hr = records_o; end
            if (clear_o) break;
            @(posedge clock); #1;
            if (rnd) ready_i = ($urandom_range(0, 1) == 1);
        end
        ready_i = 1'b1;
        #1;
        total_cnt++;
        if (d >= budget) $display("FAIL clear_timeout: waited %0d cycles, required clear_o within %0d", d, budget);
        else pass_cnt++;
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        #13;
        @(negedge clock) resetn = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %0b want 0", valid_o); else pass_cnt++;
        total_cnt++; if (clear_o !== 1'b0) $display("FAIL rst_clear: got %0b want 0", clear_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy_o); else pass_cnt++;
        total_cnt++; if (data_o !== 32'd0) $display("FAIL rst_data: got %0h want 0", data_o); else pass_cnt++;
        total_cnt++; if (add_o !== 13'd0) $display("FAIL rst_add: got %0d want 0", add_o); else pass_cnt++;
        total_cnt++; if (records_o !== 32'd0) $display("FAIL rst_records: got %0d want 0", records_o); else pass_cnt++;
        @(negedge clock) resetn = 1'b1;
    endtask

    task automatic test_basic();
        int d, c0; logic hv; logic [31:0] hd, hr;
        exp_c = 32'd3; c0 = clear_cnt;
        pulse_start(32'd3);
        wait_clear(200, 1'b0, d, hv, hd, hr);
        total_cnt++; if (hv !== 1'b1 || hd !== 32'd3) $display("FAIL basic_header: got v=%0b d=%0d want v=1 d=3", hv, hd); else pass_cnt++;
        total_cnt++; if (d != 28) $display("FAIL basic_clear_time: got %0d want 28", d); else pass_cnt++;
        total_cnt++; if (word_idx != 16 || word_err != 0) $display("FAIL basic_stream: got %0d words %0d bad want 16 words 0 bad", word_idx, word_err); else pass_cnt++;
        total_cnt++; if (records_o !== 32'd3) $display("FAIL basic_records: got %0d want 3", records_o); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (clear_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL basic_end: got clear=%0b busy=%0b want 0 0", clear_o, busy_o); else pass_cnt++;
        total_cnt++; if (clear_cnt - c0 != 1) $display("FAIL basic_clear_count: got %0d want 1", clear_cnt - c0); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int d, c0, s0; logic hv; logic [31:0] hd, hr;
        exp_c = 32'd2; c0 = clear_cnt; s0 = stall_err;
        pulse_start(32'd2);
        wait_clear(2000, 1'b1, d, hv, hd, hr);
        total_cnt++; if (word_idx != 11 || word_err != 0) $display("FAIL bp_stream: got %0d words %0d bad want 11 words 0 bad", word_idx, word_err); else pass_cnt++;
        total_cnt++; if (stall_err != s0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err - s0); else pass_cnt++;
        total_cnt++; if (records_o !== 32'd2 || clear_cnt - c0 != 1) $display("FAIL bp_end: got rec=%0d clears=%0d want 2 1", records_o, clear_cnt - c0); else pass_cnt++;
    endtask

    task automatic test_empty_clamp();
        int d, c0, s0; logic hv; logic [31:0] hd, hr;
        exp_c = 32'd0; c0 = clear_cnt;
        pulse_start(32'd0);
        wait_clear(20, 1'b0, d, hv, hd, hr);
        total_cnt++; if (hv !== 1'b1 || hd !== 32'd0) $display("FAIL empty_header: got v=%0b d=%0d want v=1 d=0", hv, hd); else pass_cnt++;
        total_cnt++; if (d != 1) $display("FAIL empty_clear_time: got %0d want 1", d); else pass_cnt++;
        total_cnt++; if (word_idx != 1 || clear_cnt - c0 != 1) $display("FAIL empty_stream: got %0d words %0d clears want 1 1", word_idx, clear_cnt - c0); else pass_cnt++;
        exp_c = 32'd8192; s0 = stall_err;
        ready_i = 1'b0;
        pulse_start(32'd20000);
        repeat (4) @(negedge clock);
        total_cnt++; if (valid_o !== 1'b1 || data_o !== 32'd8192) $display("FAIL clamp_header: got v=%0b d=%0d want v=1 d=8192", valid_o, data_o); else pass_cnt++;
        total_cnt++; if (stall_err != s0) $display("FAIL clamp_stall: got %0d unstable stalls want 0", stall_err - s0); else pass_cnt++;
        do_reset();
        ready_i = 1'b1;
    endtask

    task automatic test_ignored_start();
        int d, c0; logic hv; logic [31:0] hd, hr;
        exp_c = 32'd3; c0 = clear_cnt;
        pulse_start(32'd3);
        repeat (10) @(posedge clock);
        #1;
        used_i = 32'd5; start_i = 1'b1; auto_i = 1'b1; full_i = 1'b1;
        @(posedge clock); #1;
        start_i = 1'b0;
        wait_clear(200, 1'b0, d, hv, hd, hr);
        total_cnt++; if (word_idx != 16 || word_err != 0) $display("FAIL ign_stream: got %0d words %0d bad want 16 words 0 bad", word_idx, word_err); else pass_cnt++;
        total_cnt++; if (records_o !== 32'd3) $display("FAIL ign_records: got %0d want 3", records_o); else pass_cnt++;
        repeat (4) @(negedge clock);
        total_cnt++; if (busy_o !== 1'b0 || clear_cnt - c0 != 1) $display("FAIL ign_restart: got busy=%0b clears=%0d want 0 1", busy_o, clear_cnt - c0); else pass_cnt++;
        full_i = 1'b0; auto_i = 1'b0;
        exp_c = 32'd1;
        pulse_start(32'd1);
        wait_clear(200, 1'b0, d, hv, hd, hr);
        total_cnt++; if (hr !== 32'd0 || hd !== 32'd1) $display("FAIL fresh_start: got rec=%0d hdr=%0d want 0 1", hr, hd); else pass_cnt++;
        total_cnt++; if (word_idx != 6 || word_err != 0 || records_o !== 32'd1) $display("FAIL fresh_stream: got %0d words %0d bad rec=%0d want 6 0 1", word_idx, word_err, records_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d, c0; logic hv; logic [31:0] hd, hr; bit hit;
        exp_c = 32'd3; c0 = clear_cnt; hit = 1'b0;
        pulse_start(32'd3);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock); #1;
            if (word_idx == 9) begin hit = 1'b1; break; end
        end
        total_cnt++; if (!hit) $display("FAIL mid_reach: got word_idx=%0d want 9", word_idx); else pass_cnt++;
        resetn = 1'b0;
        #1;
        total_cnt++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || add_o !== 13'd0) $display("FAIL mid_reset: got v=%0b busy=%0b add=%0d want 0 0 0", valid_o, busy_o, add_o); else pass_cnt++;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        total_cnt++; if (clear_cnt != c0) $display("FAIL mid_no_clear: got %0d clears want 0", clear_cnt - c0); else pass_cnt++;
        pulse_start(32'd3);
        wait_clear(200, 1'b0, d, hv, hd, hr);
        total_cnt++; if (word_idx != 16 || word_err != 0 || clear_cnt - c0 != 1) $display("FAIL mid_redrain: got %0d words %0d bad %0d clears want 16 0 1", word_idx, word_err, clear_cnt - c0); else pass_cnt++;
    endtask

    task automatic test_auto();
        int d, c0; logic hv; logic [31:0] hd, hr;
        exp_c = 32'd8192; c0 = clear_cnt;
        @(posedge clock); #1;
        used_i = 32'd8192; auto_i = 1'b1; full_i = 1'b1;
        @(posedge clock); #1;
        wait_clear(80000, 1'b0, d, hv, hd, hr);
        total_cnt++; if (hv !== 1'b1 || hd !== 32'd8192) $display("FAIL auto_header: got v=%0b d=%0d want v=1 d=8192", hv, hd); else pass_cnt++;
        total_cnt++; if (word_idx != 40961 || word_err != 0) $display("FAIL auto_stream: got %0d words %0d bad want 40961 0", word_idx, word_err); else pass_cnt++;
        total_cnt++; if (wrap_err != 0 || max_add != 8191) $display("FAIL auto_addr: got %0d jumps max=%0d want 0 8191", wrap_err, max_add); else pass_cnt++;
        total_cnt++; if (records_o !== 32'd8192 || clear_cnt - c0 != 1) $display("FAIL auto_end: got rec=%0d clears=%0d want 8192 1", records_o, clear_cnt - c0); else pass_cnt++;
        full_i = 1'b0; auto_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_clamp();
        test_ignored_start();
        test_reset_mid();
        test_auto();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
